hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 datapath. It keeps a three-slot scoreboard that shadows the instructions in EX, MEM and WB, and drives four outputs:
- the four forwarding enables consumed by the EX stage;
- front-end stall and ID/EX bubble insertion for load-use hazards;
- back-end freeze while data memory is busy;
- IF/ID + ID/EX flush on a taken branch, with deferral across a memory wait.

It sits beside the datapath and owns no datapath values, only register addresses and control bits.

## Interface
Parameters:
- RegAddrW, default 5: register address width.

Ports:
- iClk  in  1  pipeline clock, all state on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- iEn  in  1  global enable; low is treated exactly as iMemBusy high, with the flush deferred.
- iIdValid  in  1  ID holds a real instruction.
- iIdRs1, iIdRs2  in  RegAddrW  source register addresses of the instruction in ID.
- iIdUsesRs1, iIdUsesRs2  in  1  instruction reads rs1/rs2; rs2 is 0 when the immediate is selected.
- iIdRd  in  RegAddrW  destination of the instruction in ID.
- iIdRdWe  in  1  instruction writes rd.
- iIdLoad  in  1  instruction is a load.
- iExBranchTaken  in  1  one-cycle pulse from EX, taken branch/jump resolved.
- iMemBusy  in  1  data memory not ready; the MEM stage must hold.
- oStallFront  out  1  hold PC and IF/ID.
- oBubble  out  1  load a NOP into ID/EX instead of the ID instruction.
- oStallBack  out  1  hold ID/EX, EX/MEM and MEM/WB (drives EX iStall).
- oFlush  out  1  clear IF/ID and ID/EX; PC takes the branch target.
- oFwExS1_en, oFwExS2_en  out  1  EX operand from the EX/MEM result.
- oFwMeS1_en, oFwMeS2_en  out  1  EX operand from the MEM/WB value.

## Operation
- Scoreboard slots sEx, sMem, sWb each hold {valid, rd, we, load, rs1, rs2, use1, use2}.
- When the back end advances (oStallBack=0):
  - sWb<=sMem, sMem<=sEx.
  - sEx<=ID fields if iIdValid & !oBubble & !oFlush; otherwise sEx is invalid.
- Match(slot, r) = slot.valid & slot.we & (slot.rd==r) & (r!=0).
- Forwarding is combinational from registers only:
  - oFwExSn_en = sEx.usen & Match(sMem, sEx.rsn).
  - oFwMeSn_en = sEx.usen & Match(sWb, sEx.rsn) & !oFwExSn_en (the younger producer wins).
  - The Ex and Me enables for the same operand are never both 1.
- Load-use condition: sEx.load & Match(sEx, ID source with its use bit set) & iIdValid.
- FSM states:
  - RUN: normal operation.
  - LDSTALL: one bubble has been issued.
  - MEMWAIT: back end frozen.
- Priority for simultaneous events: memory busy/!iEn > flush > load-use.
  - MEMWAIT: entered from any state when iMemBusy | !iEn. Outputs oStallFront=1, oStallBack=1, oBubble=0. Scoreboard holds. The state is left to RUN the first cycle busy is low.
  - pendFlush: set when iExBranchTaken arrives while in or entering MEMWAIT. On exit from MEMWAIT, oFlush=1 is issued for that exit cycle and pendFlush is cleared.
  - Flush (RUN, iExBranchTaken or pendFlush): oFlush=1 for exactly one cycle, no stall, state stays RUN. A concurrent load-use is ignored because the ID instruction is killed.
  - RUN + load-use: oStallFront=1, oBubble=1, oStallBack=0, next state is LDSTALL.
  - LDSTALL: outputs are those of RUN. The load is now in sMem, so one bubble is sufficient and the data arrives via oFwMe the following cycle. Next state is RUN.
- x0 is never forwarded or stalled on.

## Timing
- Reset: state RUN, pendFlush=0, all slots invalid, all outputs 0.
- Reset asserted mid-stall or mid-flush forces the above immediately; no flush is replayed.
- Forwarding enables are valid the same cycle as the consuming instruction in EX. There is no added latency.
- Stall and bubble outputs are combinational from ID inputs and state. They are valid before the rising edge.
- Load-use costs exactly 1 cycle. A taken branch costs 2 squashed instructions.
- iMemBusy held for N cycles gives N cycles of full stall. Forwarding outputs stay constant during the stall.

## Structure
- pipeline_types gains:
  - hz_slot_t (scoreboard slot struct);
  - hz_state_e {RUN, LDSTALL, MEMWAIT}.
- One sub-module, hz_match: slot/address comparator with x0 masking, instantiated 6×.
- Estimated size: about 200 RTL lines.

## Test plan
- Back-to-back ALU forwarding:
  - Stimulus: add x5←…, then sub x6←x5,x5.
  - Required: in the sub's EX cycle oFwExS1_en=oFwExS2_en=1 and both Me enables are 0.
  - Stimulus: a third instruction reads x5.
  - Required: oFwMeS1_en=1.
- Load-use:
  - Stimulus: lw x7, then add x8←x7,x1.
  - Required: one cycle with oStallFront=1, oBubble=1; the next cycle the add in EX sees oFwMeS1_en=1 and no stall.
- x0 and immediates:
  - Stimulus: addi x0 followed by a reader of x0.
  - Required: all forwarding enables 0.
  - Stimulus: rd match on rs2 with iIdUsesRs2=0.
  - Required: S2 enables 0.
- Memory wait with branch:
  - Stimulus: iMemBusy high for 3 cycles, iExBranchTaken pulsed in the 1st of them.
  - Required: oStallFront=oStallBack=1 for 3 cycles, then oFlush=1 on exactly the following cycle.
- Priority:
  - Stimulus: load-use and iExBranchTaken in the same cycle.
  - Required: oFlush=1, oBubble=0, next state RUN.
- Reset:
  - Stimulus: nRst low during LDSTALL and during MEMWAIT with pendFlush set.
  - Required: all outputs 0 asynchronously; after release, no flush is issued.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: scoreboard slot and FSM state types shared by the hazard controller
// HZ_AW is the widest register address a slot can hold; narrower addresses are zero-extended.
package hazard_ctrl_pkg;
  localparam int HZ_AW = 8;
  typedef struct packed {
    logic             valid;
    logic [HZ_AW-1:0] rd;
    logic             we;
    logic             load;
    logic [HZ_AW-1:0] rs1;
    logic [HZ_AW-1:0] rs2;
    logic             use1;
    logic             use2;
  } hz_slot_t;
  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} hz_state_e;
endpackage

// File: rtl/hazard_ctrl_match.sv
// hz_match: producer-slot vs source-address comparator with x0 masking
// Ports: i_use (source is read), i_valid/i_we/i_rd (producer slot), i_rs (source address), o_match.
module hz_match #(
  parameter int W = 8
) (
  input  logic         i_use,
  input  logic         i_valid,
  input  logic         i_we,
  input  logic [W-1:0] i_rd,
  input  logic [W-1:0] i_rs,
  output logic         o_match
);
  assign o_match = i_use & i_valid & i_we & (i_rd == i_rs) & (|i_rs);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, memory-wait freeze and branch flush for the 5-stage RV32 pipe
// Ports: iClk/nRst clock and async active-low reset; iEn global enable; iId* describe the ID instruction;
//        iExBranchTaken taken-branch pulse; iMemBusy data-memory wait; oStallFront/oBubble/oStallBack/oFlush
//        pipeline control; oFwExSn_en / oFwMeSn_en select EX operand n from EX/MEM or MEM/WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RegAddrW = 5
) (
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iEn,
  input  logic                iIdValid,
  input  logic [RegAddrW-1:0] iIdRs1,
  input  logic [RegAddrW-1:0] iIdRs2,
  input  logic                iIdUsesRs1,
  input  logic                iIdUsesRs2,
  input  logic [RegAddrW-1:0] iIdRd,
  input  logic                iIdRdWe,
  input  logic                iIdLoad,
  input  logic                iExBranchTaken,
  input  logic                iMemBusy,
  output logic                oStallFront,
  output logic                oBubble,
  output logic                oStallBack,
  output logic                oFlush,
  output logic                oFwExS1_en,
  output logic                oFwExS2_en,
  output logic                oFwMeS1_en,
  output logic                oFwMeS2_en
);
  hz_slot_t  r_ex, r_mem, r_wb, w_id;
  hz_state_e r_state, w_state;
  logic      r_pend, w_pend;
  logic      w_hold, w_lu, w_lu1, w_lu2;
  logic      w_ex1, w_ex2, w_me1, w_me2;
  logic      w_sf, w_bub, w_sb, w_fl;
  assign w_id = '{valid: 1'b1, rd: HZ_AW'(iIdRd), we: iIdRdWe, load: iIdLoad,
                  rs1: HZ_AW'(iIdRs1), rs2: HZ_AW'(iIdRs2), use1: iIdUsesRs1, use2: iIdUsesRs2};
  hz_match #(.W(HZ_AW)) u_ex1 (.i_use(r_ex.use1), .i_valid(r_mem.valid), .i_we(r_mem.we),
                               .i_rd(r_mem.rd), .i_rs(r_ex.rs1), .o_match(w_ex1));
  hz_match #(.W(HZ_AW)) u_ex2 (.i_use(r_ex.use2), .i_valid(r_mem.valid), .i_we(r_mem.we),
                               .i_rd(r_mem.rd), .i_rs(r_ex.rs2), .o_match(w_ex2));
  hz_match #(.W(HZ_AW)) u_me1 (.i_use(r_ex.use1), .i_valid(r_wb.valid), .i_we(r_wb.we),
                               .i_rd(r_wb.rd), .i_rs(r_ex.rs1), .o_match(w_me1));
  hz_match #(.W(HZ_AW)) u_me2 (.i_use(r_ex.use2), .i_valid(r_wb.valid), .i_we(r_wb.we),
                               .i_rd(r_wb.rd), .i_rs(r_ex.rs2), .o_match(w_me2));
  hz_match #(.W(HZ_AW)) u_lu1 (.i_use(iIdUsesRs1), .i_valid(r_ex.valid), .i_we(r_ex.we),
                               .i_rd(r_ex.rd), .i_rs(w_id.rs1), .o_match(w_lu1));
  hz_match #(.W(HZ_AW)) u_lu2 (.i_use(iIdUsesRs2), .i_valid(r_ex.valid), .i_we(r_ex.we),
                               .i_rd(r_ex.rd), .i_rs(w_id.rs2), .o_match(w_lu2));
  assign oFwExS1_en = w_ex1;
  assign oFwExS2_en = w_ex2;
  assign oFwMeS1_en = w_me1 & !w_ex1;
  assign oFwMeS2_en = w_me2 & !w_ex2;
  assign w_hold = iMemBusy | !iEn;
  assign w_lu   = iIdValid & r_ex.load & (w_lu1 | w_lu2);
  // Memory wait outranks flush, which outranks load-use. In LDSTALL the load has already moved
  // past EX, so a second bubble is never issued from that state.
  always_comb begin
    w_state = RUN;
    w_pend  = 1'b0;
    w_sf    = 1'b0;
    w_sb    = 1'b0;
    w_bub   = 1'b0;
    w_fl    = 1'b0;
    if (w_hold) begin
      w_state = MEMWAIT;
      w_pend  = r_pend | iExBranchTaken;
      w_sf    = 1'b1;
      w_sb    = 1'b1;
    end else if (iExBranchTaken | r_pend) begin
      w_fl = 1'b1;
    end else if (w_lu && r_state != LDSTALL) begin
      w_state = LDSTALL;
      w_sf    = 1'b1;
      w_bub   = 1'b1;
    end
  end
  // Control outputs are forced low while reset is asserted, independent of the clock.
  assign oStallFront = nRst & w_sf;
  assign oStallBack  = nRst & w_sb;
  assign oBubble     = nRst & w_bub;
  assign oFlush      = nRst & w_fl;
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= RUN;
      r_pend  <= 1'b0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state;
      r_pend  <= w_pend;
      if (!w_sb) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= (iIdValid & !w_bub & !w_fl) ? w_id : '0;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  logic       iClk = 1'b0, nRst = 1'b1, iEn = 1'b1;
  logic       iIdValid = 1'b0, iIdUsesRs1 = 1'b0, iIdUsesRs2 = 1'b0, iIdRdWe = 1'b0, iIdLoad = 1'b0;
  logic [4:0] iIdRs1 = '0, iIdRs2 = '0, iIdRd = '0;
  logic       iExBranchTaken = 1'b0, iMemBusy = 1'b0;
  logic       oStallFront, oBubble, oStallBack, oFlush;
  logic       oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en;
  logic [7:0] w_out;
  logic [7:0] q_exp[$];
  string      q_name[$];
  int         checks = 0, errors = 0;
  // control word {nRst, branch, busy, en}
  localparam logic [3:0] N = 4'b1001, BR = 4'b1101, BZ = 4'b1011, BZBR = 4'b1111, EN0 = 4'b1000;
  localparam logic [3:0] RST = 4'b0001, RSTBR = 4'b0101, RSTBZ = 4'b0011;
  always #5 iClk = ~iClk;
  hazard_ctrl #(.RegAddrW(5)) dut (
    .iClk(iClk), .nRst(nRst), .iEn(iEn), .iIdValid(iIdValid), .iIdRs1(iIdRs1), .iIdRs2(iIdRs2),
    .iIdUsesRs1(iIdUsesRs1), .iIdUsesRs2(iIdUsesRs2), .iIdRd(iIdRd), .iIdRdWe(iIdRdWe),
    .iIdLoad(iIdLoad), .iExBranchTaken(iExBranchTaken), .iMemBusy(iMemBusy),
    .oStallFront(oStallFront), .oBubble(oBubble), .oStallBack(oStallBack), .oFlush(oFlush),
    .oFwExS1_en(oFwExS1_en), .oFwExS2_en(oFwExS2_en), .oFwMeS1_en(oFwMeS1_en), .oFwMeS2_en(oFwMeS2_en)
  );
  assign w_out = {oStallFront, oBubble, oStallBack, oFlush, oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en};
  // output order: {stallFront, bubble, stallBack, flush, fwEx1, fwEx2, fwMe1, fwMe2}
  always @(negedge iClk) begin
    logic [7:0] e;
    string      n;
    if (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      n = q_name.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", n, w_out, e);
      end
    end
  end
  task automatic cyc(input string n, input logic [3:0] c, input logic v, input logic [4:0] rs1, rs2,
                     input logic u1, u2, input logic [4:0] rd, input logic we, ld, input logic [7:0] exp);
    @(posedge iClk);
    #1;
    {nRst, iExBranchTaken, iMemBusy, iEn} = c;
    iIdValid = v; iIdRs1 = rs1; iIdRs2 = rs2; iIdUsesRs1 = u1; iIdUsesRs2 = u2;
    iIdRd = rd; iIdRdWe = we; iIdLoad = ld;
    q_name.push_back(n);
    q_exp.push_back(exp);
  endtask
  initial begin
    #2 nRst = 1'b0;
    cyc("reset",        RST,   0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("add5",         N,     1,  1,  2, 1, 1,  5, 1, 0, 8'h00);
    cyc("sub6",         N,     1,  5,  5, 1, 1,  6, 1, 0, 8'h00);
    cyc("fw_ex_both",   N,     1,  5,  3, 1, 1,  9, 1, 0, 8'h0C);
    cyc("fw_me_s1",     N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h02);
    cyc("addi_x0",      N,     1,  1,  0, 1, 0,  0, 1, 0, 8'h00);
    cyc("read_x0",      N,     1,  0,  0, 1, 1, 10, 1, 0, 8'h00);
    cyc("x0_no_fw",     N,     1,  5, 10, 1, 0, 11, 1, 0, 8'h00);
    cyc("imm_no_s2",    N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("w12_a",        N,     1,  1,  1, 1, 1, 12, 1, 0, 8'h00);
    cyc("w12_b",        N,     1,  3,  4, 1, 1, 12, 1, 0, 8'h00);
    cyc("r12",          N,     1, 12, 12, 1, 1, 13, 1, 0, 8'h00);
    cyc("younger_wins", N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h0C);
    cyc("lw7",          N,     1,  2,  0, 1, 0,  7, 1, 1, 8'h00);
    cyc("ld_use_s1",    N,     1,  7,  1, 1, 1,  8, 1, 0, 8'hC0);
    cyc("ldstall_run",  N,     1,  7,  1, 1, 1,  8, 1, 0, 8'h00);
    cyc("ld_fw_me1",    N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h02);
    cyc("lw7_b",        N,     1,  2,  0, 1, 0,  7, 1, 1, 8'h00);
    cyc("ld_use_s2",    N,     1,  1,  7, 1, 1,  8, 1, 0, 8'hC0);
    cyc("ldstall_s2",   N,     1,  1,  7, 1, 1,  8, 1, 0, 8'h00);
    cyc("ld_fw_me2",    N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h01);
    cyc("lw7_c",        N,     1,  2,  0, 1, 0,  7, 1, 1, 8'h00);
    cyc("br_over_lu",   BR,    1,  7,  1, 1, 1,  8, 1, 0, 8'h10);
    cyc("after_flush",  N,     1,  7,  1, 1, 1,  8, 1, 0, 8'h00);
    cyc("post_fl_fw",   N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h02);
    cyc("add9",         N,     1,  8,  8, 1, 1,  9, 1, 0, 8'h00);
    cyc("busy1_br",     BZBR,  0,  0,  0, 0, 0,  0, 0, 0, 8'hA3);
    cyc("busy2",        BZ,    0,  0,  0, 0, 0,  0, 0, 0, 8'hA3);
    cyc("busy3",        BZ,    0,  0,  0, 0, 0,  0, 0, 0, 8'hA3);
    cyc("pend_flush",   N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h13);
    cyc("flush_once",   N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("en_low",       EN0,   0,  0,  0, 0, 0,  0, 0, 0, 8'hA0);
    cyc("en_back",      N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("lw7_d",        N,     1,  2,  0, 1, 0,  7, 1, 1, 8'h00);
    cyc("ld_use_d",     N,     1,  7,  1, 1, 1,  8, 1, 0, 8'hC0);
    cyc("rst_ldstall",  RSTBR, 1,  7,  1, 1, 1,  8, 1, 0, 8'h00);
    cyc("rel_ldstall",  N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("busy_br_pend", BZBR,  0,  0,  0, 0, 0,  0, 0, 0, 8'hA0);
    cyc("rst_memwait",  RSTBZ, 0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("no_replay",    N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    cyc("idle_end",     N,     0,  0,  0, 0, 0,  0, 0, 0, 8'h00);
    repeat (3) @(negedge iClk);
    #1;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
